udp_tx_arbiter: RTL and testbench

// Shares the single UDP transmit port of udp_ip_mac_top between two frame sources,
// e.g. the FFT spectrum buffer and the FIR audio buffer.

---
 rtl/udp_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares the UDP TX port between two frame sources.
// Startup ARP, round-robin grant, request/ack handshake, one-frame drain.
module udp_tx_arbiter #(
  parameter int CH0_LEN     = 512,
  parameter int CH1_LEN     = 512,
  parameter int START_DLY   = 125_000_000,
  parameter int ACK_TIMEOUT = 1_000_000,
  parameter int IFG_CYC     = 16
) (
  input  logic        rgmii_clk,
  input  logic        rstn,
  input  logic        ch0_frame_rdy,
  output logic        ch0_rd_en,
  input  logic [7:0]  ch0_rd_data,
  input  logic        ch1_frame_rdy,
  output logic        ch1_rd_en,
  input  logic [7:0]  ch1_rd_data,
  output logic        arp_req,
  output logic        app_data_request,
  output logic [15:0] app_data_length,
  output logic        app_data_in_valid,
  output logic [7:0]  app_data_in,
  input  logic        udp_send_ack,
  input  logic        mac_send_end,
  output logic        grant_ch,
  output logic        busy,
  output logic        ack_timeout_err
);

  typedef enum logic [2:0] {
    S_STARTUP,
    S_ARP_REQ,
    S_ARP_WAIT,
    S_ARB,
    S_REQ,
    S_DATA,
    S_END_WAIT,
    S_GAP
  } state_t;

  localparam logic [31:0] START_LAST = 32'(START_DLY - 1);
  localparam logic [31:0] ACK_LAST   = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST   = 32'(IFG_CYC - 1);
  localparam logic [15:0] LEN0       = 16'(CH0_LEN);
  localparam logic [15:0] LEN1       = 16'(CH1_LEN);

  state_t      state;
  logic [31:0] cnt;
  logic [15:0] byte_cnt;
  logic        last_grant;
  logic        rd_en_d1;
  logic        pick1;

  // ch1 wins alone, or on a tie when ch0 had the last grant
  always_comb begin
    pick1 = ch1_frame_rdy && (!ch0_frame_rdy || !last_grant);
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      state            <= S_STARTUP;
      cnt              <= '0;
      byte_cnt         <= '0;
      last_grant       <= 1'b1;
      arp_req          <= 1'b0;
      app_data_request <= 1'b0;
      app_data_length  <= '0;
      grant_ch         <= 1'b0;
      busy             <= 1'b0;
      ack_timeout_err  <= 1'b0;
      ch0_rd_en        <= 1'b0;
      ch1_rd_en        <= 1'b0;
    end else begin
      arp_req <= 1'b0;
      unique case (state)
        S_STARTUP: begin
          if (cnt == START_LAST) begin
            cnt     <= '0;
            arp_req <= 1'b1;
            state   <= S_ARP_REQ;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_ARP_REQ: state <= S_ARP_WAIT;
        S_ARP_WAIT: begin
          if (mac_send_end) state <= S_ARB;
        end
        S_ARB: begin
          if (ch0_frame_rdy || ch1_frame_rdy) begin
            grant_ch         <= pick1;
            last_grant       <= pick1;
            app_data_length  <= pick1 ? LEN1 : LEN0;
            app_data_request <= 1'b1;
            busy             <= 1'b1;
            cnt              <= '0;
            state            <= S_REQ;
          end
        end
        S_REQ: begin
          if (udp_send_ack) begin
            app_data_request <= 1'b0;
            byte_cnt         <= '0;
            ch0_rd_en        <= !grant_ch;
            ch1_rd_en        <= grant_ch;
            state            <= S_DATA;
          end else if (cnt == ACK_LAST) begin
            app_data_request <= 1'b0;
            busy             <= 1'b0;
            ack_timeout_err  <= 1'b1;
            arp_req          <= 1'b1;
            cnt              <= '0;
            state            <= S_ARP_REQ;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_DATA: begin
          if (byte_cnt == app_data_length - 16'd1) begin
            ch0_rd_en <= 1'b0;
            ch1_rd_en <= 1'b0;
            state     <= S_END_WAIT;
          end else begin
            byte_cnt <= byte_cnt + 16'd1;
          end
        end
        S_END_WAIT: begin
          // hold off until the last byte has left the delay line
          if (mac_send_end && !rd_en_d1 && !app_data_in_valid) begin
            busy  <= 1'b0;
            cnt   <= '0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_ARB;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= S_STARTUP;
      endcase
    end
  end

  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      rd_en_d1          <= 1'b0;
      app_data_in_valid <= 1'b0;
      app_data_in       <= '0;
    end else begin
      rd_en_d1          <= ch0_rd_en | ch1_rd_en;
      app_data_in_valid <= rd_en_d1;
      app_data_in       <= grant_ch ? ch1_rd_data : ch0_rd_data;
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed stimulus with a frame scoreboard.
// Expected frames are queued by stimulus and checked by a monitor.
module tb_udp_tx_arbiter;

  localparam int L0   = 8;
  localparam int L1   = 20;
  localparam int SDLY = 100;
  localparam int ATO  = 50;
  localparam int IFG  = 16;

  logic        rgmii_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ch0_frame_rdy = 1'b0;
  logic        ch0_rd_en;
  logic [7:0]  ch0_rd_data = '0;
  logic        ch1_frame_rdy = 1'b0;
  logic        ch1_rd_en;
  logic [7:0]  ch1_rd_data = '0;
  logic        arp_req;
  logic        app_data_request;
  logic [15:0] app_data_length;
  logic        app_data_in_valid;
  logic [7:0]  app_data_in;
  logic        udp_send_ack = 1'b0;
  logic        mac_send_end = 1'b0;
  logic        grant_ch;
  logic        busy;
  logic        ack_timeout_err;

  udp_tx_arbiter #(
    .CH0_LEN(L0),
    .CH1_LEN(L1),
    .START_DLY(SDLY),
    .ACK_TIMEOUT(ATO),
    .IFG_CYC(IFG)
  ) dut (
    .rgmii_clk(rgmii_clk),
    .rstn(rstn),
    .ch0_frame_rdy(ch0_frame_rdy),
    .ch0_rd_en(ch0_rd_en),
    .ch0_rd_data(ch0_rd_data),
    .ch1_frame_rdy(ch1_frame_rdy),
    .ch1_rd_en(ch1_rd_en),
    .ch1_rd_data(ch1_rd_data),
    .arp_req(arp_req),
    .app_data_request(app_data_request),
    .app_data_length(app_data_length),
    .app_data_in_valid(app_data_in_valid),
    .app_data_in(app_data_in),
    .udp_send_ack(udp_send_ack),
    .mac_send_end(mac_send_end),
    .grant_ch(grant_ch),
    .busy(busy),
    .ack_timeout_err(ack_timeout_err)
  );

  always #4 rgmii_clk = ~rgmii_clk;

  typedef struct {
    bit         ch;
    int         len;
    logic [7:0] first;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] f0 = 8'h00;
  logic [7:0] f1 = 8'h00;
  logic [7:0] p0 = 8'h00;
  logic [7:0] p1 = 8'h00;

  // source FIFOs: word returned the cycle after the read strobe
  always @(posedge rgmii_clk) begin
    if (ch0_rd_en) begin
      ch0_rd_data <= f0;
      f0 <= f0 + 8'd1;
    end
    if (ch1_rd_en) begin
      ch1_rd_data <= 8'h80 + f1;
      f1 <= f1 + 8'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return app_data_request;
      1: return app_data_in_valid;
      2: return ch0_rd_en;
      3: return ch1_rd_en;
      default: return arp_req;
    endcase
  endfunction

  task automatic wait_level(input string name, input int sel,
                            input logic lvl, input int lim);
    int i;
    i = 0;
    while (i < lim && sig(sel) !== lvl) begin
      @(negedge rgmii_clk);
      i++;
    end
    if (i == lim) begin
      checks++;
      errors++;
      $display("FAIL %s: still not %0d after %0d cycles", name, lvl, lim);
    end
  endtask

  task automatic pulse_end();
    mac_send_end = 1'b1;
    @(negedge rgmii_clk);
    mac_send_end = 1'b0;
  endtask

  task automatic do_frame(input bit ch, input bit early);
    exp_t e;
    e.ch = ch;
    e.len = ch ? L1 : L0;
    if (ch) begin
      e.first = 8'h80 + p1;
      p1 = p1 + 8'(L1);
    end else begin
      e.first = p0;
      p0 = p0 + 8'(L0);
    end
    exp_q.push_back(e);
    wait_level("req_rise", 0, 1'b1, 300);
    repeat (3) @(negedge rgmii_clk);
    udp_send_ack = 1'b1;
    @(negedge rgmii_clk);
    udp_send_ack = 1'b0;
    if (early) begin
      repeat (2) @(negedge rgmii_clk);
      pulse_end();
      wait_level("rd_fall", ch ? 3 : 2, 1'b0, 40);
      pulse_end();
    end
    wait_level("vld_rise", 1, 1'b1, 40);
    wait_level("vld_fall", 1, 1'b0, 60);
    pulse_end();
  endtask

  task automatic arp_after_reset(input string name);
    int k;
    int reqs;
    k = 0;
    reqs = 0;
    while (k < 300) begin
      @(negedge rgmii_clk);
      k++;
      if (app_data_request) reqs++;
      if (arp_req) break;
    end
    chk({name, "_arp_cycle"}, k, SDLY);
    @(negedge rgmii_clk);
    chk({name, "_arp_width"}, {31'd0, arp_req}, 0);
    repeat (10) begin
      @(negedge rgmii_clk);
      if (app_data_request) reqs++;
    end
    chk({name, "_no_req"}, reqs, 0);
  endtask

  function automatic logic [31:0] out_vec();
    return {arp_req, app_data_request, app_data_length,
            app_data_in_valid, app_data_in, grant_ch, busy,
            ack_timeout_err, ch0_rd_en, ch1_rd_en};
  endfunction

  // monitor: gathers each valid burst and scores it against the queue
  logic [7:0] bytes[$];
  int rd0 = 0;
  int rd1 = 0;

  always @(negedge rgmii_clk) begin
    if (!rstn) begin
      bytes.delete();
      rd0 = 0;
      rd1 = 0;
    end else begin
      if (ch0_rd_en) rd0++;
      if (ch1_rd_en) rd1++;
      if (app_data_in_valid) begin
        bytes.push_back(app_data_in);
      end else if (bytes.size() > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0d-byte frame, expected none",
                   bytes.size());
        end else begin
          exp_t e;
          int nbad;
          e = exp_q.pop_front();
          nbad = 0;
          foreach (bytes[i])
            if (bytes[i] !== 8'(int'(e.first) + i)) nbad++;
          chk("sb_grant", {31'd0, grant_ch}, {31'd0, e.ch});
          chk("sb_length", {16'd0, app_data_length}, e.len);
          chk("sb_nbytes", bytes.size(), e.len);
          chk("sb_data_bad", nbad, 0);
          chk("sb_rd_granted", e.ch ? rd1 : rd0, e.len);
          chk("sb_rd_other", e.ch ? rd0 : rd1, 0);
        end
        bytes.delete();
        rd0 = 0;
        rd1 = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #5;
    chk("reset_outputs", out_vec(), 0);
    ch0_frame_rdy = 1'b1;
    @(negedge rgmii_clk);
    rstn = 1'b1;
    arp_after_reset("t1");
    pulse_end();

    do_frame(1'b0, 1'b1);
    ch1_frame_rdy = 1'b1;
    n = 1;
    while (!app_data_request && n < 60) begin
      @(negedge rgmii_clk);
      n++;
    end
    chk("t6_gap_cycles", n, IFG + 2);

    do_frame(1'b1, 1'b0);
    do_frame(1'b0, 1'b0);
    do_frame(1'b1, 1'b0);
    do_frame(1'b0, 1'b0);

    wait_level("t4_req_rise", 0, 1'b1, 300);
    chk("t4_grant", {31'd0, grant_ch}, 1);
    n = 0;
    while (app_data_request && n < 200) begin
      n++;
      @(negedge rgmii_clk);
    end
    chk("t4_req_cycles", n, ATO);
    chk("t4_err", {31'd0, ack_timeout_err}, 1);
    chk("t4_arp", {31'd0, arp_req}, 1);
    @(negedge rgmii_clk);
    chk("t4_arp_width", {31'd0, arp_req}, 0);
    pulse_end();

    wait_level("t5_req_rise", 0, 1'b1, 300);
    chk("t5_grant", {31'd0, grant_ch}, 0);
    repeat (3) @(negedge rgmii_clk);
    udp_send_ack = 1'b1;
    @(negedge rgmii_clk);
    udp_send_ack = 1'b0;
    wait_level("t5_vld_rise", 1, 1'b1, 40);
    repeat (3) @(negedge rgmii_clk);
    chk("t5_pre_rd_en", {31'd0, ch0_rd_en}, 1);
    chk("t5_pre_err", {31'd0, ack_timeout_err}, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_reset_outputs", out_vec(), 0);
    @(negedge rgmii_clk);
    @(negedge rgmii_clk);
    rstn = 1'b1;
    arp_after_reset("t5");

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
